ram2_req_ctrl: RTL and testbench
================================

Name: ram2_req_ctrl

Overview:
- Request front-end directly upstream of the RAM2 controller.
- Accepts instruction-fetch requests from IF and load/store requests from EXE, and arbitrates between them (EXE wins).
- Issues a fresh 32-bit transaction token (mem_act) per access and drives the controller's need_to_work_*/address/data inputs.
- Waits for the token-qualified done, returns data to the pipeline, and raises stall while any request is outstanding.

Parameters:
- ADDR_W, 18, memory address width (matches `MemAddr).
- DATA_W, 16, memory data width (matches `MemValue).
- TIMEOUT, 64, cycles to wait for done before retry (used only with RAM2_REQ_TIMEOUT_EN).

Ports:
- clk in 1: system clock, all state on posedge.
- rst in 1: reset, asynchronous, active-low.
- if_req in 1: IF requests a fetch, level, held until if_valid.
- if_addr in ADDR_W: fetch address.
- exe_rd in 1: EXE load request, level, held until exe_valid.
- exe_wr in 1: EXE store request, level, held until exe_valid.
- exe_addr in ADDR_W: load/store address.
- exe_wdata in DATA_W: store data.
- if_work_done in 1: from RAM2 controller, already token-qualified.
- exe_work_done in 1: from RAM2 controller, already token-qualified.
- if_result in DATA_W: fetched word from the controller.
- exe_result in DATA_W: loaded word from the controller.
- need_to_work_if out 1: to controller.
- need_to_work_exe out 1: to controller.
- mem_rd out 1: to controller.
- exe_mem_wr out 1: to controller.
- mem_addr_if out ADDR_W: to controller.
- mem_addr_exe out ADDR_W: to controller.
- mem_value_exe out DATA_W: to controller.
- mem_act out 32: transaction token.
- if_valid out 1: one-cycle pulse, if_data valid.
- if_data out DATA_W: fetched word.
- exe_valid out 1: one-cycle pulse, exe_data valid.
- exe_data out DATA_W: loaded word (store: don't care).
- stall out 1: pipeline hold.

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0, including mem_act=32'h0; latched address/data registers 0.
- States: IDLE, EXE_BUSY, IF_BUSY, RESP.
- IDLE, exe_rd|exe_wr=1:
  - Latch exe_addr, exe_wdata, rd/wr; mem_act<=mem_act+1.
  - Next cycle: need_to_work_exe=1, mem_rd=latched rd, exe_mem_wr=latched wr; go EXE_BUSY.
  - exe_rd and exe_wr both set: treat as read; wr ignored.
- IDLE, else if if_req=1: latch if_addr, mem_act+1, need_to_work_if=1; go IF_BUSY.
- Simultaneous IF and EXE requests: EXE first. IF is served on the first IDLE cycle after EXE completes, if if_req is still high.
- EXE_BUSY: hold all outputs stable until exe_work_done=1. On that edge:
  - exe_data<=exe_result (reads only);
  - drop need_to_work_exe, mem_rd, exe_mem_wr;
  - exe_valid=1 for exactly one cycle (registered); go RESP.
- IF_BUSY: symmetric, using if_work_done, if_result, if_data, if_valid.
- RESP: one cycle for the requester to drop its req; then IDLE. Requests seen in RESP are ignored, so every access costs ≥1 idle cycle.
- Latency, request to valid: 1 (issue) + controller 4 (IDLE→R1→R2→R3) + 1 (capture) = 6 cycles nominal.
- stall = (if_req|exe_rd|exe_wr) & ~(if_valid|exe_valid), combinational. A requester whose pulse is showing is not stalled.
- Token: increments by exactly 1 per issue and never per retry-less cycle. Wraps 32'hFFFFFFFF→32'h0. A done whose token does not match is blocked by the controller, so no stale completion is accepted.
- Async reset mid-transaction: return to IDLE immediately with no valid pulse. The requester re-asserts after reset; a new token is issued.

Optional Feature:
- Macro: RAM2_REQ_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter, cleared on issue, counts in *_BUSY.
  - On reaching TIMEOUT-1 without done: mem_act+1 (re-issue the same request); counter clears.
  - Sticky output err_timeout (1 bit, reset 0) sets on the first retry.
- Undefined: no counter, no err_timeout port; waits indefinitely.

Decomposition:
- Shared package/defines file:
  - state encodings (IDLE=2'd0, EXE_BUSY=2'd1, IF_BUSY=2'd2, RESP=2'd3);
  - `MemAddr/`MemValue widths; 32-bit token width constant.
- One sub-module: ram2_act_gen, the token counter with inc strobe and async active-low reset.

Test Plan:
- Reset, then if_req=1, if_addr=0x00010, controller model returns 0xBEEF → mem_act=1, need_to_work_if high cycles 1-5, if_valid pulse cycle 6, if_data=0xBEEF, stall low from cycle 6.
- Simultaneous if_req and exe_rd (addr 0x00200, data 0x1234) → EXE served first (mem_act=1, exe_data=0x1234); IF issued afterwards with mem_act=2.
- exe_wr, addr 0x00300, wdata 0xA5A5 → mem_value_exe=0xA5A5, exe_mem_wr=1 held until done; exe_valid single pulse; mem_rd=0 throughout.
- Preload mem_act=32'hFFFFFFFF via back-to-back requests in model, then issue → token wraps to 0, done still accepted.
- rst low during EXE_BUSY → all outputs 0 asynchronously, no exe_valid; after release, a reasserted exe_rd issues mem_act=1.
- With RAM2_REQ_TIMEOUT_EN, TIMEOUT=8, model never raises done → token increments every 8 cycles; err_timeout=1 after first retry; done on the third token completes normally.

Source files
------------

// File: rtl/ram2_req_ctrl_pkg.sv
// Shared widths, token width and FSM state encoding for the RAM2 request front-end.
package ram2_req_ctrl_pkg;

  localparam int unsigned MEM_ADDR_W  = 18;
  localparam int unsigned MEM_VALUE_W = 16;
  localparam int unsigned ACT_W       = 32;
  localparam int unsigned WAIT_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXE_BUSY = 2'd1,
    IF_BUSY  = 2'd2,
    RESP     = 2'd3
  } req_state_e;

  function automatic logic exe_pending(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/ram2_req_ctrl_act_gen.sv
// ram2_act_gen: 32-bit transaction token counter, +1 per inc strobe, wraps to 0.
module ram2_act_gen
  import ram2_req_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [ACT_W-1:0] act
);

  logic [ACT_W-1:0] act_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q <= '0;
    end else if (inc) begin
      act_q <= act_q + {{(ACT_W-1){1'b0}}, 1'b1};
    end
  end

  assign act = act_q;

endmodule

// File: rtl/ram2_req_ctrl.sv
// RAM2 request front-end: arbitrates IF/EXE accesses (EXE wins), issues a token
// per access and returns controller data. Optional retry timer: RAM2_REQ_TIMEOUT_EN.
module ram2_req_ctrl
  import ram2_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_VALUE_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              exe_rd,
  input  logic              exe_wr,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  input  logic              if_work_done,
  input  logic              exe_work_done,
  input  logic [DATA_W-1:0] if_result,
  input  logic [DATA_W-1:0] exe_result,
  output logic              need_to_work_if,
  output logic              need_to_work_exe,
  output logic              mem_rd,
  output logic              exe_mem_wr,
  output logic [ADDR_W-1:0] mem_addr_if,
  output logic [ADDR_W-1:0] mem_addr_exe,
  output logic [DATA_W-1:0] mem_value_exe,
  output logic [ACT_W-1:0]  mem_act,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  output logic              exe_valid,
  output logic [DATA_W-1:0] exe_data,
  output logic              stall
`ifdef RAM2_REQ_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("ram2_req_ctrl: TIMEOUT must be at least 2");
  end

  req_state_e        state_q, state_d;
  logic              ntw_if_q, ntw_if_d;
  logic              ntw_exe_q, ntw_exe_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_if_q, addr_if_d;
  logic [ADDR_W-1:0] addr_exe_q, addr_exe_d;
  logic [DATA_W-1:0] value_exe_q, value_exe_d;
  logic              if_valid_q, if_valid_d;
  logic              exe_valid_q, exe_valid_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] exe_data_q, exe_data_d;
  logic              issue;
  logic              retry;
  logic              timeout_hit;

`ifdef RAM2_REQ_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  err_q;

  assign timeout_hit = (wait_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (issue || retry) begin
        wait_cnt_q <= '0;
      end else if (state_q == EXE_BUSY || state_q == IF_BUSY) begin
        wait_cnt_q <= wait_cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
      end
      if (retry) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ntw_if_d    = ntw_if_q;
    ntw_exe_d   = ntw_exe_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_if_d   = addr_if_q;
    addr_exe_d  = addr_exe_q;
    value_exe_d = value_exe_q;
    if_data_d   = if_data_q;
    exe_data_d  = exe_data_q;
    if_valid_d  = 1'b0;
    exe_valid_d = 1'b0;
    issue       = 1'b0;
    retry       = 1'b0;

    case (state_q)
      IDLE: begin
        if (exe_pending(exe_rd, exe_wr)) begin
          // A simultaneous rd+wr is treated as a plain read.
          addr_exe_d  = exe_addr;
          value_exe_d = exe_wdata;
          rd_d        = exe_rd;
          wr_d        = exe_wr & ~exe_rd;
          ntw_exe_d   = 1'b1;
          issue       = 1'b1;
          state_d     = EXE_BUSY;
        end else if (if_req) begin
          addr_if_d = if_addr;
          ntw_if_d  = 1'b1;
          issue     = 1'b1;
          state_d   = IF_BUSY;
        end
      end
      EXE_BUSY: begin
        if (exe_work_done) begin
          if (rd_q) begin
            exe_data_d = exe_result;
          end
          ntw_exe_d   = 1'b0;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          exe_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timeout_hit) begin
          retry = 1'b1;
        end
      end
      IF_BUSY: begin
        if (if_work_done) begin
          if_data_d  = if_result;
          ntw_if_d   = 1'b0;
          if_valid_d = 1'b1;
          state_d    = RESP;
        end else if (timeout_hit) begin
          retry = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ntw_if_q    <= 1'b0;
      ntw_exe_q   <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_if_q   <= '0;
      addr_exe_q  <= '0;
      value_exe_q <= '0;
      if_data_q   <= '0;
      exe_data_q  <= '0;
      if_valid_q  <= 1'b0;
      exe_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ntw_if_q    <= ntw_if_d;
      ntw_exe_q   <= ntw_exe_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_if_q   <= addr_if_d;
      addr_exe_q  <= addr_exe_d;
      value_exe_q <= value_exe_d;
      if_data_q   <= if_data_d;
      exe_data_q  <= exe_data_d;
      if_valid_q  <= if_valid_d;
      exe_valid_q <= exe_valid_d;
    end
  end

  ram2_act_gen u_act (
    .clk (clk),
    .rst (rst),
    .inc (issue | retry),
    .act (mem_act)
  );

  assign need_to_work_if  = ntw_if_q;
  assign need_to_work_exe = ntw_exe_q;
  assign mem_rd           = rd_q;
  assign exe_mem_wr       = wr_q;
  assign mem_addr_if      = addr_if_q;
  assign mem_addr_exe     = addr_exe_q;
  assign mem_value_exe    = value_exe_q;
  assign if_valid         = if_valid_q;
  assign if_data          = if_data_q;
  assign exe_valid        = exe_valid_q;
  assign exe_data         = exe_data_q;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall = rst & (if_req | exe_rd | exe_wr) & ~(if_valid_q | exe_valid_q);

endmodule

// File: tb/tb_ram2_req_ctrl.sv
// Directed self-checking bench for ram2_req_ctrl; the bench plays the RAM2 controller.
module tb_ram2_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [17:0] if_addr = '0;
  logic        exe_rd = 1'b0;
  logic        exe_wr = 1'b0;
  logic [17:0] exe_addr = '0;
  logic [15:0] exe_wdata = '0;
  logic        if_work_done = 1'b0;
  logic        exe_work_done = 1'b0;
  logic [15:0] if_result = '0;
  logic [15:0] exe_result = '0;
  logic        need_to_work_if, need_to_work_exe, mem_rd, exe_mem_wr;
  logic [17:0] mem_addr_if, mem_addr_exe;
  logic [15:0] mem_value_exe;
  logic [31:0] mem_act;
  logic        if_valid, exe_valid, stall;
  logic [15:0] if_data, exe_data;
`ifdef RAM2_REQ_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram2_req_ctrl #(.ADDR_W(18), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .exe_rd(exe_rd), .exe_wr(exe_wr), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
    .if_work_done(if_work_done), .exe_work_done(exe_work_done),
    .if_result(if_result), .exe_result(exe_result),
    .need_to_work_if(need_to_work_if), .need_to_work_exe(need_to_work_exe),
    .mem_rd(mem_rd), .exe_mem_wr(exe_mem_wr),
    .mem_addr_if(mem_addr_if), .mem_addr_exe(mem_addr_exe),
    .mem_value_exe(mem_value_exe), .mem_act(mem_act),
    .if_valid(if_valid), .if_data(if_data),
    .exe_valid(exe_valid), .exe_data(exe_data),
    .stall(stall)
`ifdef RAM2_REQ_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    // ---------------- reset state
    tick();
    tick();
    chk("rst_ntw_if", {31'b0, need_to_work_if}, 32'd0);
    chk("rst_ntw_exe", {31'b0, need_to_work_exe}, 32'd0);
    chk("rst_mem_act", mem_act, 32'h0);
    chk("rst_addr_if", {14'b0, mem_addr_if}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b1;
    tick();

    // ---------------- IF fetch, 6-cycle latency
    if_req = 1'b1; if_addr = 18'h00010;
    #1 chk("if_stall_c0", {31'b0, stall}, 32'd1);
    tick();
    chk("if_ntw_c1", {31'b0, need_to_work_if}, 32'd1);
    chk("if_act_c1", mem_act, 32'd1);
    chk("if_addr_c1", {14'b0, mem_addr_if}, 32'h10);
    chk("if_ntw_exe_c1", {31'b0, need_to_work_exe}, 32'd0);
    chk("if_stall_c1", {31'b0, stall}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("if_ntw_c%0d", i), {31'b0, need_to_work_if}, 32'd1);
      chk($sformatf("if_valid_c%0d", i), {31'b0, if_valid}, 32'd0);
    end
    if_work_done = 1'b1; if_result = 16'hBEEF;
    tick();
    chk("if_valid_c6", {31'b0, if_valid}, 32'd1);
    chk("if_data_c6", {16'b0, if_data}, 32'hBEEF);
    chk("if_ntw_c6", {31'b0, need_to_work_if}, 32'd0);
    chk("if_stall_c6", {31'b0, stall}, 32'd0);
    if_work_done = 1'b0; if_req = 1'b0;
    tick();
    chk("if_valid_c7", {31'b0, if_valid}, 32'd0);
    chk("if_act_c7", mem_act, 32'd1);

    // ---------------- simultaneous IF + EXE read: EXE first
    do_reset();
    if_req = 1'b1; if_addr = 18'h00044;
    exe_rd = 1'b1; exe_addr = 18'h00200;
    tick();
    chk("arb_ntw_exe", {31'b0, need_to_work_exe}, 32'd1);
    chk("arb_ntw_if", {31'b0, need_to_work_if}, 32'd0);
    chk("arb_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("arb_wr", {31'b0, exe_mem_wr}, 32'd0);
    chk("arb_addr_exe", {14'b0, mem_addr_exe}, 32'h200);
    chk("arb_act1", mem_act, 32'd1);
    tick();
    exe_work_done = 1'b1; exe_result = 16'h1234;
    tick();
    chk("arb_exe_valid", {31'b0, exe_valid}, 32'd1);
    chk("arb_exe_data", {16'b0, exe_data}, 32'h1234);
    chk("arb_mem_rd_drop", {31'b0, mem_rd}, 32'd0);
    chk("arb_stall_pulse", {31'b0, stall}, 32'd0);
    exe_work_done = 1'b0; exe_rd = 1'b0;
    tick();
    chk("arb_exe_valid_end", {31'b0, exe_valid}, 32'd0);
    chk("arb_idle_ntw_if", {31'b0, need_to_work_if}, 32'd0);
    chk("arb_idle_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("arb_if_ntw", {31'b0, need_to_work_if}, 32'd1);
    chk("arb_act2", mem_act, 32'd2);
    chk("arb_if_addr", {14'b0, mem_addr_if}, 32'h44);
    if_work_done = 1'b1; if_result = 16'h5678;
    tick();
    chk("arb_if_valid", {31'b0, if_valid}, 32'd1);
    chk("arb_if_data", {16'b0, if_data}, 32'h5678);
    if_work_done = 1'b0; if_req = 1'b0;
    tick();

    // ---------------- EXE store
    exe_wr = 1'b1; exe_addr = 18'h00300; exe_wdata = 16'hA5A5; exe_result = 16'hFFFF;
    tick();
    chk("wr_act", mem_act, 32'd3);
    chk("wr_value", {16'b0, mem_value_exe}, 32'hA5A5);
    chk("wr_addr", {14'b0, mem_addr_exe}, 32'h300);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("wr_held_%0d", i), {31'b0, exe_mem_wr}, 32'd1);
      chk($sformatf("wr_rd_%0d", i), {31'b0, mem_rd}, 32'd0);
      chk($sformatf("wr_novalid_%0d", i), {31'b0, exe_valid}, 32'd0);
      tick();
    end
    exe_work_done = 1'b1;
    tick();
    chk("wr_valid", {31'b0, exe_valid}, 32'd1);
    chk("wr_drop", {31'b0, exe_mem_wr}, 32'd0);
    chk("wr_rd_end", {31'b0, mem_rd}, 32'd0);
    exe_work_done = 1'b0; exe_wr = 1'b0;
    tick();
    chk("wr_valid_once", {31'b0, exe_valid}, 32'd0);
    tick();

    // ---------------- token wrap
    force dut.u_act.act_q = 32'hFFFF_FFFF;
    tick();
    release dut.u_act.act_q;
    if_req = 1'b1; if_addr = 18'h3FFFF;
    tick();
    chk("wrap_act", mem_act, 32'h0);
    chk("wrap_ntw", {31'b0, need_to_work_if}, 32'd1);
    chk("wrap_addr", {14'b0, mem_addr_if}, 32'h3FFFF);
    if_work_done = 1'b1; if_result = 16'h0F0F;
    tick();
    chk("wrap_valid", {31'b0, if_valid}, 32'd1);
    chk("wrap_data", {16'b0, if_data}, 32'h0F0F);
    if_work_done = 1'b0; if_req = 1'b0;
    tick();
    tick();

    // ---------------- async reset during EXE_BUSY
    exe_rd = 1'b1; exe_addr = 18'h00123;
    tick();
    chk("ar_busy", {31'b0, need_to_work_exe}, 32'd1);
    tick();
    #2 rst = 1'b0; exe_work_done = 1'b1; exe_result = 16'hDEAD;
    #1;
    chk("ar_ntw_exe", {31'b0, need_to_work_exe}, 32'd0);
    chk("ar_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("ar_act", mem_act, 32'h0);
    chk("ar_addr", {14'b0, mem_addr_exe}, 32'd0);
    chk("ar_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("ar_no_valid", {31'b0, exe_valid}, 32'd0);
    rst = 1'b1; exe_work_done = 1'b0;
    tick();
    chk("ar_reissue_act", mem_act, 32'd1);
    chk("ar_reissue_ntw", {31'b0, need_to_work_exe}, 32'd1);
    chk("ar_reissue_addr", {14'b0, mem_addr_exe}, 32'h123);
    chk("ar_reissue_novalid", {31'b0, exe_valid}, 32'd0);
    exe_work_done = 1'b1; exe_result = 16'hCAFE;
    tick();
    chk("ar_valid", {31'b0, exe_valid}, 32'd1);
    chk("ar_data", {16'b0, exe_data}, 32'hCAFE);
    exe_work_done = 1'b0; exe_rd = 1'b0;
    tick();

`ifdef RAM2_REQ_TIMEOUT_EN
    // ---------------- retry on timeout (TIMEOUT=8)
    do_reset();
    if_req = 1'b1; if_addr = 18'h00050;
    tick();
    chk("to_act1", mem_act, 32'd1);
    chk("to_err0", {31'b0, err_timeout}, 32'd0);
    repeat (7) tick();
    chk("to_act1_hold", mem_act, 32'd1);
    chk("to_err0_hold", {31'b0, err_timeout}, 32'd0);
    tick();
    chk("to_act2", mem_act, 32'd2);
    chk("to_err1", {31'b0, err_timeout}, 32'd1);
    chk("to_ntw", {31'b0, need_to_work_if}, 32'd1);
    repeat (7) tick();
    chk("to_act2_hold", mem_act, 32'd2);
    tick();
    chk("to_act3", mem_act, 32'd3);
    if_work_done = 1'b1; if_result = 16'h7777;
    tick();
    chk("to_valid", {31'b0, if_valid}, 32'd1);
    chk("to_data", {16'b0, if_data}, 32'h7777);
    chk("to_err_sticky", {31'b0, err_timeout}, 32'd1);
    if_work_done = 1'b0; if_req = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
